// File: rtl/nibble_sub_sequencer.sv
// nibble_sub_sequencer: multi-cycle W-bit subtraction sequenced one nibble per cycle through an external 4-bit subtractor
module nibble_sub_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] opA,
  input  logic [4*NIBBLES-1:0] opB,
  input  logic                 borrow_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 borrow_out,
  output logic                 overflow,
  output logic                 zero,
  output logic [3:0]           sub_A,
  output logic [3:0]           sub_B,
  output logic                 sub_BorrowIN,
  input  logic [3:0]           sub_Y,
  input  logic                 sub_BorrowOUT
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a, b, shadow, shadow_n;
  logic [KW-1:0] k;
  logic run_borrow, last;
  assign last = k == KW'(NIBBLES - 1);
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    busy         = state == RUN;
    done         = state == DONE;
    sub_A        = busy ? a[k*4 +: 4] : 4'd0;
    sub_B        = busy ? b[k*4 +: 4] : 4'd0;
    sub_BorrowIN = busy & run_borrow;
  end
  // the final nibble is merged combinationally so the result lands on the edge entering DONE
  always_comb begin
    shadow_n = shadow;
    shadow_n[k*4 +: 4] = sub_Y;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a          <= '0;
      b          <= '0;
      shadow     <= '0;
      k          <= '0;
      run_borrow <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
    end else if (state == IDLE && start) begin
      a          <= opA;
      b          <= opB;
      k          <= '0;
      run_borrow <= borrow_in;
    end else if (state == RUN) begin
      shadow     <= shadow_n;
      run_borrow <= sub_BorrowOUT;
      k          <= k + 1'b1;
      if (last) begin
        result     <= shadow_n;
        borrow_out <= sub_BorrowOUT;
        overflow   <= (a[W-1] != b[W-1]) && (shadow_n[W-1] != a[W-1]);
        zero       <= shadow_n == '0;
      end
    end
  end
endmodule

// File: tb/tb_nibble_sub_sequencer.sv
// tb_nibble_sub_sequencer: randomized and directed checks against a full-width arithmetic reference model
module tb_nibble_sub_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, reset = 1, start = 0, borrow_in = 0;
  logic [W-1:0] opA = 0, opB = 0;
  logic busy, done, borrow_out, overflow, zero, sub_BorrowIN, sub_BorrowOUT;
  logic [W-1:0] result;
  logic [3:0] sub_A, sub_B, sub_Y;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  // external 4-bit subtraction unit
  assign {sub_BorrowOUT, sub_Y} = {1'b0, sub_A} - {1'b0, sub_B} - {4'd0, sub_BorrowIN};

  nibble_sub_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB), .borrow_in(borrow_in),
    .busy(busy), .done(done), .result(result), .borrow_out(borrow_out), .overflow(overflow),
    .zero(zero), .sub_A(sub_A), .sub_B(sub_B), .sub_BorrowIN(sub_BorrowIN),
    .sub_Y(sub_Y), .sub_BorrowOUT(sub_BorrowOUT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // reference: plain integer subtraction on the full width
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int signed d;
    logic [W-1:0] r;
    d = int'(a) - int'(b) - int'(bi);
    r = d[W-1:0];
    return {d < 0, (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]), r == 0, r};
  endfunction

  function automatic logic low_borrow(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input int k);
    int m;
    m = 1 << (4 * k);
    return (int'(a) % m) - (int'(b) % m) - int'(bi) < 0;
  endfunction

  task automatic expect_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W+2:0] m;
    m = model(a, b, bi);
    check({tag, ".result"}, 32'(result), 32'(m[W-1:0]));
    check({tag, ".borrow_out"}, 32'(borrow_out), 32'(m[W+2]));
    check({tag, ".overflow"}, 32'(overflow), 32'(m[W+1]));
    check({tag, ".zero"}, 32'(zero), 32'(m[W]));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit pulse);
    int cyc;
    @(negedge clk);
    start = 1; opA = a; opB = b; borrow_in = bi;
    cyc = 0;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
      start = pulse && cyc == 2;
      opA = W'($urandom); opB = W'($urandom); borrow_in = 1'($urandom);
      if (done) break;
      check({tag, ".busy"}, 32'(busy), 32'(cyc <= N));
      if (cyc <= N) begin
        check({tag, ".sub_A"}, 32'(sub_A), 32'((a >> (4 * (cyc - 1))) & 4'hF));
        check({tag, ".sub_B"}, 32'(sub_B), 32'((b >> (4 * (cyc - 1))) & 4'hF));
        check({tag, ".sub_BorrowIN"}, 32'(sub_BorrowIN), 32'(low_borrow(a, b, bi, cyc - 1)));
      end
    end
    check({tag, ".latency"}, 32'(cyc), 32'(N + 1));
    expect_result(tag, a, b, bi);
    check({tag, ".sub_A_idle"}, 32'({sub_A, sub_B, sub_BorrowIN}), 32'(0));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'(0));
    expect_result({tag, ".hold"}, a, b, bi);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic bi;
    int gap, last_done, cyc, ndone;
    repeat (2) @(negedge clk);
    check("reset.outs", 32'({busy, done, borrow_out, overflow, zero, sub_BorrowIN}), 32'(0));
    check("reset.data", 32'({result, sub_A, sub_B}), 32'(0));
    reset = 0;

    run_op("r034", 16'h0006, 16'h0002, 1'b0, 0);
    run_op("r035", 16'h0002, 16'h0006, 1'b0, 0);
    run_op("r036a", 16'h8000, 16'h0001, 1'b0, 0);
    run_op("r036b", 16'h1000, 16'h0001, 1'b0, 0);
    run_op("r037a", 16'hFFFF, 16'h0001, 1'b1, 0);
    run_op("r037b", 16'h1234, 16'h1234, 1'b0, 0);
    run_op("r038pulse", 16'h0006, 16'h0002, 1'b0, 1);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      ndone += int'(done);
    end
    check("r038.no_queued_done", 32'(ndone), 32'(0));

    for (int i = 0; i < 25; i++) begin
      a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
      if (i % 5 == 0) b = a;
      run_op("rand", a, b, bi, 0);
    end

    // start held high with constant operands
    @(negedge clk);
    start = 1; opA = 16'hA5C3; opB = 16'h5A3C; borrow_in = 1;
    last_done = -1; cyc = 0; ndone = 0;
    while (cyc < 40 && ndone < 4) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last_done >= 0) check("held.period", 32'(cyc - last_done), 32'(6));
        expect_result("held", 16'hA5C3, 16'h5A3C, 1'b1);
        last_done = cyc;
        ndone++;
      end
    end
    check("held.count", 32'(ndone), 32'(4));
    start = 0;
    repeat (8) @(negedge clk);

    // reset during the second RUN cycle aborts the operation
    start = 1; opA = 16'h1111; opB = 16'h0222; borrow_in = 0;
    @(negedge clk);
    start = 0;
    check("abort.busy1", 32'(busy), 32'(1));
    @(negedge clk);
    check("abort.busy2", 32'(busy), 32'(1));
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("abort.outs", 32'({busy, done, borrow_out, overflow, zero, sub_BorrowIN}), 32'(0));
    check("abort.data", 32'({result, sub_A, sub_B}), 32'(0));
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      ndone += int'(done | busy);
    end
    check("abort.no_done", 32'(ndone), 32'(0));
    run_op("after_abort", 16'h7000, 16'h8001, 1'b1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
